// File: rtl/dbus_req_ctrl_pkg.sv
// Shared data-bus request/response types and access-size encodings
// used by the memory stage and the core's dbus port.
package dbus_req_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_req_ctrl.sv
// Sequences the memory stage's single outstanding dbus transaction: stalls until data
// returns, holds read data until the stage advances, drains flushed requests, counts stalls.
module dbus_req_ctrl
  import dbus_req_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        stage_req,
  input  logic             advance,
  input  logic             flush,
  output dbus_req_t        bus_req,
  input  dbus_resp_t       bus_resp,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;

  logic issue, req_vld, addr_acc, data_acc, in_flight, drain_now, capture;
  state_t fin_state;

  always_comb begin
    issue     = (state_q == IDLE) && stage_req.valid && !flush;
    req_vld   = !reset && (issue || (state_q == ADDR));
    addr_acc  = req_vld && bus_resp.addr_ok;
    // A data_ok is only ours once the address has been accepted; stray beats are dropped.
    data_acc  = !reset && bus_resp.data_ok && (addr_acc || (state_q == DATA));
    in_flight = (state_q == ADDR) || (state_q == DATA);
    drain_now = drain_q || (flush && in_flight);
    capture   = data_acc && !drain_now;
    // If the stage already left in the data cycle there is nothing to hold.
    fin_state = (drain_now || advance) ? IDLE : DONE;

    state_d = state_q;
    drain_d = drain_now && !data_acc;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (data_acc)      state_d = fin_state;
          else if (addr_acc) state_d = DATA;
          else               state_d = ADDR;
        end
      end
      ADDR: begin
        if (data_acc)      state_d = fin_state;
        else if (addr_acc) state_d = DATA;
      end
      DATA: begin
        if (data_acc) state_d = fin_state;
      end
      DONE: begin
        if (advance || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req       = stage_req;
    bus_req.valid = req_vld;
    // While draining a killed request, any waiting instruction stalls even on the drain's data_ok.
    stall = !reset && stage_req.valid && !flush && (state_q != DONE) &&
            (drain_now || !data_acc);
    rdata = capture ? bus_resp.data : rdata_q;
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (capture) rdata_q <= bus_resp.data;
      if (stall)   cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Bench for dbus_req_ctrl: directed handshake scenarios plus randomized traffic against
// a flag-based transaction model (address pending, data pending, held result, killed).
module tb_dbus_req_ctrl;
  import dbus_req_ctrl_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, advance, flush, stall;
  dbus_req_t        stage_req, bus_req;
  dbus_resp_t       bus_resp;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: address outstanding, data outstanding, result held, transaction killed.
  bit               m_pa, m_pd, m_have, m_dead;
  logic [31:0]      m_rq;
  logic [CNT_W-1:0] m_cnt;
  bit               n_pa, n_pd, n_have, n_dead;
  logic [31:0]      n_rq;
  logic [CNT_W-1:0] n_cnt;
  bit               e_bvalid, e_stall;
  logic [31:0]      e_rdata;
  logic [CNT_W-1:0] e_cnt;

  always #5 clk = ~clk;

  dbus_req_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stage_req (stage_req),
    .advance   (advance),
    .flush     (flush),
    .bus_req   (bus_req),
    .bus_resp  (bus_resp),
    .stall     (stall),
    .rdata     (rdata),
    .stall_cnt (stall_cnt)
  );

  // Drive one cycle's inputs and compute the expected outputs at the falling edge.
  task automatic apply(input bit rst, input bit v, input bit fl, input bit adv,
                       input bit aok, input bit dok, input logic [31:0] d);
    bit busy, iss, a, dd, dead, got;
    reset = rst; stage_req.valid = v; flush = fl; advance = adv;
    bus_resp.addr_ok = aok; bus_resp.data_ok = dok; bus_resp.data = d;
    @(negedge clk);
    e_cnt = m_cnt;
    n_pa = m_pa; n_pd = m_pd; n_have = m_have; n_dead = m_dead; n_rq = m_rq; n_cnt = m_cnt;
    if (rst) begin
      e_bvalid = 1'b0; e_stall = 1'b0; e_rdata = m_rq;
      n_pa = 0; n_pd = 0; n_have = 0; n_dead = 0; n_rq = 32'h0; n_cnt = '0;
    end else begin
      busy     = m_pa || m_pd;
      iss      = !busy && !m_have && v && !fl;
      e_bvalid = iss || m_pa;
      a        = e_bvalid && aok;
      dd       = (a || m_pd) && dok;
      dead     = m_dead || (busy && fl);
      got      = dd && !dead;
      e_stall  = v && !fl && !m_have && (dead || !dd);
      e_rdata  = got ? d : m_rq;
      if (got) n_rq = d;
      if (m_have) n_have = !(adv || fl);
      else if (dd) begin n_pa = 0; n_pd = 0; n_dead = 0; n_have = got && !adv; end
      else if (a) begin n_pa = 0; n_pd = 1; n_dead = dead; end
      else begin if (iss) n_pa = 1; n_dead = dead; end
      n_cnt = m_cnt + CNT_W'(e_stall);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_pa = n_pa; m_pd = n_pd; m_have = n_have; m_dead = n_dead; m_rq = n_rq; m_cnt = n_cnt;
    #1;
  endtask

  task automatic test_reset();
    stage_req = '0; bus_resp = '0;
    apply(1, 1, 0, 0, 0, 0, 32'h0); tick();
    apply(1, 1, 0, 0, 1, 1, 32'h1234);
    tests++;
    if ({bus_req.valid, stall, rdata, stall_cnt} !== {1'b0, 1'b0, 32'h0, 8'd0}) begin
      fails++;
      $display("FAIL reset_outputs got v=%b s=%b rd=%h cnt=%0d exp v=0 s=0 rd=0 cnt=0",
               bus_req.valid, stall, rdata, stall_cnt);
    end
    tick();
    apply(0, 1, 0, 0, 0, 0, 32'h0);
    tests++;
    if ({bus_req.valid, stall} !== {e_bvalid, e_stall}) begin
      fails++;
      $display("FAIL reset_first_issue got v=%b s=%b exp v=%b s=%b",
               bus_req.valid, stall, e_bvalid, e_stall);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'h40; stage_req.size = MSIZE4; stage_req.strobe = 4'hF; stage_req.data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      apply(0, c != 1, 0, c == 0, c == 0, c == 0, (c == 0) ? 32'hDEADBEEF : 32'h0);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL zw_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c == 0) begin
        tests++;
        if ({bus_req.valid, stall, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
          fails++;
          $display("FAIL zw_cycle0 got v=%b s=%b rd=%h exp v=1 s=0 rd=deadbeef", bus_req.valid, stall, rdata);
        end
      end
      if (c == 1) begin
        tests++;
        if ({bus_req.valid, stall, stall_cnt} !== {1'b0, 1'b0, 8'd0}) begin
          fails++;
          $display("FAIL zw_single_valid got v=%b s=%b cnt=%0d exp v=0 s=0 cnt=0", bus_req.valid, stall, stall_cnt);
        end
      end
      if (c == 2) begin
        tests++;
        if (bus_req.valid !== 1'b1) begin
          fails++;
          $display("FAIL zw_back_idle got v=%b exp v=1", bus_req.valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_delayed();
    bit xs, xv;
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'h80; stage_req.size = MSIZE4; stage_req.strobe = 4'h0;
    for (int c = 0; c < 7; c++) begin
      apply(0, c <= 5, 0, c == 5, c == 2, c == 5, (c == 5) ? 32'h12345678 : 32'h0);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL dly_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c <= 5) begin
        xs = (c < 5); xv = (c <= 2);
        tests++;
        if ({stall, bus_req.valid} !== {xs, xv}) begin
          fails++;
          $display("FAIL dly_timing c%0d got s=%b v=%b exp s=%b v=%b", c, stall, bus_req.valid, xs, xv);
        end
      end
      if (c == 5) begin
        tests++;
        if (rdata !== 32'h12345678) begin
          fails++;
          $display("FAIL dly_rdata got %h exp 12345678", rdata);
        end
      end
      if (c == 6) begin
        tests++;
        if (stall_cnt !== 8'd5) begin
          fails++;
          $display("FAIL dly_stall_cnt got %0d exp 5", stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_held();
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'hC0;
    for (int c = 0; c < 6; c++) begin
      apply(0, 1, 0, c == 4, c == 0, c == 1, (c == 1) ? 32'hA5A50F0F : 32'h0);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL held_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c >= 1 && c <= 4) begin
        tests++;
        if ({stall, rdata} !== {1'b0, 32'hA5A50F0F}) begin
          fails++;
          $display("FAIL held_data c%0d got s=%b rd=%h exp s=0 rd=a5a50f0f", c, stall, rdata);
        end
      end
      if (c == 2 || c == 3) begin
        tests++;
        if (bus_req.valid !== 1'b0) begin
          fails++;
          $display("FAIL held_no_reissue c%0d got v=%b exp v=0", c, bus_req.valid);
        end
      end
      if (c == 5) begin
        tests++;
        if (bus_req.valid !== 1'b1) begin
          fails++;
          $display("FAIL held_idle_after_adv got v=%b exp v=1", bus_req.valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_store();
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'h100; stage_req.size = MSIZE2; stage_req.strobe = 4'b0011;
    stage_req.data = 32'hCAFE0000;
    for (int c = 0; c < 5; c++) begin
      apply(0, c <= 3, 0, c == 3, c == 2, c == 3, (c == 3) ? 32'h77777777 : 32'h0);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL st_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c <= 2) begin
        tests++;
        if ({bus_req.valid, bus_req.addr, bus_req.size, bus_req.strobe, bus_req.data}
            !== {1'b1, 32'h100, MSIZE2, 4'b0011, 32'hCAFE0000}) begin
          fails++;
          $display("FAIL st_fields c%0d got v=%b a=%h sz=%0d sb=%b d=%h exp v=1 a=100 sz=1 sb=0011 d=cafe0000",
                   c, bus_req.valid, bus_req.addr, bus_req.size, bus_req.strobe, bus_req.data);
        end
      end
      if (c == 3) begin
        tests++;
        if ({bus_req.valid, stall} !== {1'b0, 1'b0}) begin
          fails++;
          $display("FAIL st_release got v=%b s=%b exp v=0 s=0", bus_req.valid, stall);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush_addr();
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'h140; stage_req.size = MSIZE4; stage_req.strobe = 4'h0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) stage_req.addr = 32'h200;
      apply(0, (c <= 1) || (c >= 4), c == 1, c == 5, (c == 3) || (c == 5), c >= 4,
            (c == 4) ? 32'hBAD0BAD0 : ((c == 5) ? 32'h00000055 : 32'h0));
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL fl_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c <= 3) begin
        tests++;
        if (bus_req.valid !== 1'b1) begin
          fails++;
          $display("FAIL fl_held_valid c%0d got v=%b exp v=1", c, bus_req.valid);
        end
      end
      if (c >= 1 && c <= 3) begin
        tests++;
        if (stall !== 1'b0) begin
          fails++;
          $display("FAIL fl_no_stall c%0d got s=%b exp s=0", c, stall);
        end
      end
      if (c == 4) begin
        tests++;
        if ({bus_req.valid, stall, rdata} !== {1'b0, 1'b1, 32'h0}) begin
          fails++;
          $display("FAIL fl_drain got v=%b s=%b rd=%h exp v=0 s=1 rd=0", bus_req.valid, stall, rdata);
        end
      end
      if (c == 5) begin
        tests++;
        if ({bus_req.valid, stall, rdata} !== {1'b1, 1'b0, 32'h00000055}) begin
          fails++;
          $display("FAIL fl_next_issue got v=%b s=%b rd=%h exp v=1 s=0 rd=55", bus_req.valid, stall, rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_in_data();
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    stage_req.addr = 32'h180;
    for (int c = 0; c < 5; c++) begin
      apply(c == 2, (c <= 2) || (c == 4), 0, 0, c == 0, c == 3, (c == 3) ? 32'hFFFF0000 : 32'h0);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL rst_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      if (c == 2) begin
        tests++;
        if ({bus_req.valid, stall} !== {1'b0, 1'b0}) begin
          fails++;
          $display("FAIL rst_outputs got v=%b s=%b exp v=0 s=0", bus_req.valid, stall);
        end
      end
      if (c == 3) begin
        tests++;
        if ({stall, rdata, stall_cnt} !== {1'b0, 32'h0, 8'd0}) begin
          fails++;
          $display("FAIL rst_stray got s=%b rd=%h cnt=%0d exp s=0 rd=0 cnt=0", stall, rdata, stall_cnt);
        end
      end
      if (c == 4) begin
        tests++;
        if ({bus_req.valid, rdata} !== {1'b1, 32'h0}) begin
          fails++;
          $display("FAIL rst_idle got v=%b rd=%h exp v=1 rd=0", bus_req.valid, rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_cnt_wrap();
    logic [CNT_W-1:0] want;
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    for (int c = 0; c < 258; c++) begin
      apply(0, 1, 0, 0, 0, 0, 32'h0);
      want = CNT_W'(c);
      tests++;
      if ({stall, stall_cnt} !== {1'b1, want}) begin
        fails++;
        $display("FAIL wrap_cnt c%0d got s=%b cnt=%0d exp s=1 cnt=%0d", c, stall, stall_cnt, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit rst, v, fl, adv, aok, dok;
    apply(1, 0, 0, 0, 0, 0, 32'h0); tick();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      adv = ($urandom_range(0, 1) == 1);
      aok = ($urandom_range(0, 1) == 1);
      dok = ($urandom_range(0, 4) < 2);
      stage_req.addr   = $urandom;
      stage_req.size   = msize_t'($urandom_range(0, 2));
      stage_req.strobe = 4'($urandom);
      stage_req.data   = $urandom;
      apply(rst, v, fl, adv, aok, dok, $urandom);
      tests++;
      if ({bus_req.valid, stall, rdata, stall_cnt} !== {e_bvalid, e_stall, e_rdata, e_cnt}) begin
        fails++;
        $display("FAIL rnd_model c%0d got v=%b s=%b rd=%h cnt=%0d exp v=%b s=%b rd=%h cnt=%0d",
                 c, bus_req.valid, stall, rdata, stall_cnt, e_bvalid, e_stall, e_rdata, e_cnt);
      end
      tests++;
      if ({bus_req.addr, bus_req.size, bus_req.strobe, bus_req.data}
          !== {stage_req.addr, stage_req.size, stage_req.strobe, stage_req.data}) begin
        fails++;
        $display("FAIL rnd_fields c%0d got a=%h d=%h exp a=%h d=%h",
                 c, bus_req.addr, bus_req.data, stage_req.addr, stage_req.data);
      end
      tick();
    end
  endtask

  initial begin
    m_pa = 0; m_pd = 0; m_have = 0; m_dead = 0; m_rq = 32'h0; m_cnt = '0;
    reset = 1'b1; advance = 1'b0; flush = 1'b0;
    stage_req = '0; bus_resp = '0;
    test_reset();
    test_zero_wait();
    test_delayed();
    test_held();
    test_store();
    test_flush_addr();
    test_reset_in_data();
    test_cnt_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
